timer_uart_tx: RTL and testbench

- Reads the timer's current minutes/seconds value and transmits it on a UART TX line as the 7-byte ASCII frame "MM:SS\r\n".
- It is the consumer end of the timer's mm/ss value interface: the timer/alarm block writes the value, and this block reads, formats and serializes it.
- Sits beside the timer block in the clock top level and drives the board's UART TX pin.
- Transmission is 8N1, LSB first, and is triggered by a one-cycle send request.

---
 rtl/timer_pkg.sv | 26 ++
 rtl/timer_uart_tx_bin2ascii2.sv | 39 +++
 rtl/timer_uart_tx.sv | 146 ++++++++++++++
 tb/tb_timer_uart_tx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants and FSM encoding for the mm:ss UART frame transmitter.
// The state encoding is kept as plain localparams so legacy code can match on it.
package timer_pkg;

   localparam logic [7:0] ASC_ZERO  = 8'h30;
   localparam logic [7:0] ASC_COLON = 8'h3A;
   localparam logic [7:0] ASC_CR    = 8'h0D;
   localparam logic [7:0] ASC_LF    = 8'h0A;

   localparam int FRAME_LEN = 7;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_START = 3'd1;
   localparam state_t ST_DATA  = 3'd2;
   localparam state_t ST_STOP  = 3'd3;
   localparam state_t ST_DONE  = 3'd4;

   localparam logic [5:0] MAX_VAL = 6'd59;

   function automatic logic [5:0] sat59(input logic [5:0] v);
      return (v > MAX_VAL) ? MAX_VAL : v;
   endfunction

endpackage

// File: rtl/timer_uart_tx_bin2ascii2.sv
// Converts a 6-bit binary value (saturated to 59) into two ASCII decimal digits.
// Purely combinational; the divide by 10 is a compare/subtract chain.
module bin2ascii2
   import timer_pkg::*;
(
   input  logic [5:0] bin,
   output logic [7:0] tens,
   output logic [7:0] units
);

   logic [5:0] rem;
   logic [2:0] digit;

   // NOTE: combinational logic uses blocking assignments with every output
   // given a default first, so no path leaves a value held (no latch).
   always_comb begin
      rem   = sat59(bin);
      digit = 3'd0;
      if (rem >= 6'd50) begin
         digit = 3'd5;
         rem   = rem - 6'd50;
      end else if (rem >= 6'd40) begin
         digit = 3'd4;
         rem   = rem - 6'd40;
      end else if (rem >= 6'd30) begin
         digit = 3'd3;
         rem   = rem - 6'd30;
      end else if (rem >= 6'd20) begin
         digit = 3'd2;
         rem   = rem - 6'd20;
      end else if (rem >= 6'd10) begin
         digit = 3'd1;
         rem   = rem - 6'd10;
      end
      tens  = ASC_ZERO + {5'd0, digit};
      units = ASC_ZERO + {2'd0, rem};
   end

endmodule

// File: rtl/timer_uart_tx.sv
// Snapshots the timer mm/ss value on a send request and transmits "MM:SS\r\n"
// as 8N1 UART, LSB first, with tx driven straight from a register.
module timer_uart_tx
   import timer_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int CNT_W        = 16
)
(
   input  logic       wt_clk,
   input  logic       rst_n,
   input  logic [5:0] mm,
   input  logic [5:0] ss,
   input  logic       send,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [2:0]       LAST_BYTE = 3'(FRAME_LEN - 1);

   state_t           state;
   logic [CNT_W-1:0] bit_cnt;
   logic [2:0]       bit_idx;
   logic [2:0]       byte_idx;
   logic [5:0]       mm_q;
   logic [5:0]       ss_q;

   logic [7:0] mm_tens, mm_units, ss_tens, ss_units;
   logic [7:0] cur_byte;
   logic       bit_end;

   bin2ascii2 u_mm_ascii (
      .bin   (mm_q),
      .tens  (mm_tens),
      .units (mm_units)
   );

   bin2ascii2 u_ss_ascii (
      .bin   (ss_q),
      .tens  (ss_tens),
      .units (ss_units)
   );

   always_comb begin
      cur_byte = ASC_LF;
      case (byte_idx)
         3'd0:    cur_byte = mm_tens;
         3'd1:    cur_byte = mm_units;
         3'd2:    cur_byte = ASC_COLON;
         3'd3:    cur_byte = ss_tens;
         3'd4:    cur_byte = ss_units;
         3'd5:    cur_byte = ASC_CR;
         default: cur_byte = ASC_LF;
      endcase
   end

   assign bit_end = (bit_cnt == '0);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge wt_clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         tx       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         bit_cnt  <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         mm_q     <= '0;
         ss_q     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            // The DONE cycle accepts a new request exactly like IDLE.
            ST_IDLE, ST_DONE: begin
               if (send) begin
                  mm_q     <= mm;
                  ss_q     <= ss;
                  busy     <= 1'b1;
                  tx       <= 1'b0;
                  bit_cnt  <= RELOAD;
                  bit_idx  <= '0;
                  byte_idx <= '0;
                  state    <= ST_START;
               end else begin
                  state <= ST_IDLE;
               end
            end

            ST_START: begin
               if (bit_end) begin
                  tx      <= cur_byte[0];
                  bit_idx <= '0;
                  bit_cnt <= RELOAD;
                  state   <= ST_DATA;
               end else begin
                  bit_cnt <= bit_cnt - CNT_ONE;
               end
            end

            ST_DATA: begin
               if (bit_end) begin
                  bit_cnt <= RELOAD;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= ST_STOP;
                  end else begin
                     tx      <= cur_byte[bit_idx + 3'd1];
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  bit_cnt <= bit_cnt - CNT_ONE;
               end
            end

            ST_STOP: begin
               if (bit_end) begin
                  if (byte_idx == LAST_BYTE) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     byte_idx <= byte_idx + 3'd1;
                     tx       <= 1'b0;
                     bit_cnt  <= RELOAD;
                     state    <= ST_START;
                  end
               end else begin
                  bit_cnt <= bit_cnt - CNT_ONE;
               end
            end

            default: begin
               tx    <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_timer_uart_tx.sv
// Randomized scoreboard bench: the driver pushes expected frame bytes and done
// times from a behavioural model; a negedge monitor decodes tx and compares.
module tb_timer_uart_tx;

   localparam int CPB     = 4;
   localparam int FRAME_C = 70 * CPB;
   localparam int BIT_C   = 10 * CPB;

   logic       wt_clk = 1'b0;
   logic       rst_n  = 1'b0;
   logic [5:0] mm     = '0;
   logic [5:0] ss     = '0;
   logic       send   = 1'b0;
   logic       tx, busy, done;

   int checks = 0;
   int errors = 0;

   int pcnt      = 0;
   int rst_edges = 0;

   logic [7:0] exp_bytes[$];
   int         exp_done[$];
   int         starts[$];

   timer_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
      .wt_clk (wt_clk),
      .rst_n  (rst_n),
      .mm     (mm),
      .ss     (ss),
      .send   (send),
      .tx     (tx),
      .busy   (busy),
      .done   (done)
   );

   always #5 wt_clk = ~wt_clk;

   always @(posedge wt_clk) begin
      pcnt = pcnt + 1;
      if (!rst_n) rst_edges = rst_edges + 1;
      else        rst_edges = 0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, pcnt, act, exp);
      end
   endtask

   // Monitor: decode the serial line and compare busy/done against the model.
   bit         dec_on = 1'b0;
   bit         glitch;
   int         k;
   logic [9:0] lvl;

   always @(negedge wt_clk) begin
      if (!rst_n) begin
         dec_on = 1'b0;
         if (rst_edges > 0) begin
            check("rst_tx", tx, 1);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
         end
      end else begin
         bit busy_exp;
         while (starts.size() > 0 && pcnt > starts[0] + FRAME_C) void'(starts.pop_front());
         busy_exp = 1'b0;
         foreach (starts[i])
            if (pcnt >= starts[i] && pcnt < starts[i] + FRAME_C) busy_exp = 1'b1;
         check("busy", busy, busy_exp);
         if (!busy_exp) check("idle_tx", tx, 1);

         if (done === 1'b1) begin
            if (exp_done.size() == 0) check("done_unexpected", 1, 0);
            else                      check("done_time", pcnt, exp_done.pop_front());
         end else if (exp_done.size() > 0 && exp_done[0] == pcnt) begin
            check("done_missing", done, 1);
            void'(exp_done.pop_front());
         end

         if (!dec_on && tx === 1'b0) begin
            dec_on = 1'b1;
            k      = 0;
            glitch = 1'b0;
         end
         if (dec_on) begin
            if (k % CPB == 0)           lvl[k / CPB] = tx;
            else if (tx !== lvl[k / CPB]) glitch = 1'b1;
            if (k == BIT_C - 1) begin
               dec_on = 1'b0;
               check("bit_stable", glitch, 0);
               check("framing", {lvl[9], lvl[0]}, 2'b10);
               if (exp_bytes.size() == 0) check("byte_unexpected", lvl[8:1], 32'h1FF);
               else                       check("byte", lvl[8:1], exp_bytes.pop_front());
            end else begin
               k = k + 1;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge wt_clk);
      #1;
   endtask

   task automatic push_frame(input int m, input int s);
      int mv, sv;
      mv = (m > 59) ? 59 : m;
      sv = (s > 59) ? 59 : s;
      exp_bytes.push_back(8'(48 + mv / 10));
      exp_bytes.push_back(8'(48 + mv % 10));
      exp_bytes.push_back(8'h3A);
      exp_bytes.push_back(8'(48 + sv / 10));
      exp_bytes.push_back(8'(48 + sv % 10));
      exp_bytes.push_back(8'h0D);
      exp_bytes.push_back(8'h0A);
   endtask

   // Issued just after a rising edge; sampled by the DUT on the next edge.
   task automatic do_send(input int m, input int s);
      int p;
      mm   = 6'(m);
      ss   = 6'(s);
      send = 1'b1;
      p    = pcnt + 1;
      if (starts.size() == 0 || p >= starts[$] + FRAME_C + 1) begin
         starts.push_back(p);
         push_frame(m, s);
         exp_done.push_back(p + FRAME_C);
      end
      tick(1);
      send = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      starts.delete();
      exp_bytes.delete();
      exp_done.delete();
      tick(n);
      rst_n = 1'b1;
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 2000 && exp_done.size() != 0; i++) tick(1);
      if (exp_done.size() != 0) check("wait_timeout", 0, 1);
      tick(2);
   endtask

   initial begin
      int a;
      tick(2);
      rst_n = 1'b1;
      tick(100);

      do_send(5, 42);
      wait_idle();

      do_send(63, 60);
      wait_idle();

      do_send(12, 0);
      tick(48);
      do_send(30, 0);
      wait_idle();

      do_send(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      a = starts[$];
      for (int i = 0; i < 400 && pcnt != a + FRAME_C; i++) tick(1);
      if (pcnt != a + FRAME_C) check("b2b_align", pcnt, a + FRAME_C);
      do_send(0, 9);
      wait_idle();

      do_send(23, 17);
      tick(90);
      do_reset(1);
      tick(5);
      do_send(47, 8);
      wait_idle();

      for (int f = 0; f < 12; f++) begin
         do_send(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
         if ($urandom_range(0, 1) == 1) begin
            tick(int'($urandom_range(1, 200)));
            do_send(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
         end
         wait_idle();
         tick(int'($urandom_range(0, 5)));
      end

      tick(10);
      check("bytes_drained", exp_bytes.size(), 0);
      check("done_drained", exp_done.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
